// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS controller: opcodes, ALU op codes,
// FSM state encoding and datapath select constants.
package lib_cpu;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ANDI  = 6'b001100,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } OPECODE;

  typedef logic [1:0] ALUOP;
  localparam ALUOP ALU_ADD   = 2'b00;
  localparam ALUOP ALU_SUB   = 2'b01;
  localparam ALUOP ALU_FUNCT = 2'b10;
  localparam ALUOP ALU_AND   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } CTRL_STATE;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_out_dec.sv
// Moore output decode: maps the current state (and opcode class) to the raw
// control word. Memory-gated strobes are qualified by ready in the top level.
module ctrl_out_dec
  import lib_cpu::*;
(
  input  logic [3:0] state_i,
  input  logic       is_bne_i,
  input  logic       is_andi_i,
  output logic       mem_req_o,
  output logic       mem_wr_o,
  output logic       ir_wr_o,
  output logic       pc_wr_o,
  output logic       pc_wr_gated_o,
  output logic       i_or_d_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       imm_zext_o,
  output logic [1:0] pc_src_o,
  output logic [1:0] alu_op_o,
  output logic       branch_o,
  output logic       bne_sel_o
);

  CTRL_STATE st;
  assign st = CTRL_STATE'(state_i);

  always_comb begin
    mem_req_o     = 1'b0;
    mem_wr_o      = 1'b0;
    ir_wr_o       = 1'b0;
    pc_wr_o       = 1'b0;
    pc_wr_gated_o = 1'b0;
    i_or_d_o      = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_dst_o     = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SRCB_B;
    imm_zext_o    = 1'b0;
    pc_src_o      = PC_ALU;
    alu_op_o      = ALU_ADD;
    branch_o      = 1'b0;
    bne_sel_o     = 1'b0;
    case (st)
      S_FETCH: begin
        mem_req_o     = 1'b1;
        ir_wr_o       = 1'b1;
        pc_wr_o       = 1'b1;
        pc_wr_gated_o = 1'b1;
        alu_src_b_o   = SRCB_FOUR;
      end
      S_DECODE: alu_src_b_o = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
        mem_wr_o  = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = PC_ALUOUT;
        branch_o    = 1'b1;
        bne_sel_o   = is_bne_i;
      end
      S_IMMEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = is_andi_i ? ALU_AND : ALU_ADD;
        imm_zext_o  = is_andi_i;
      end
      S_IMMWB: reg_write_o = 1'b1;
      S_JUMP: begin
        pc_src_o = PC_JUMP;
        pc_wr_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: state register, next-state logic,
// memory-ready gating and the PC enable equation.
module multicycle_ctrl
  import lib_cpu::*;
#(
  parameter bit MEM_HS  = 1'b1,
  parameter bit EN_BNE  = 1'b1,
  parameter bit EN_ANDI = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  CTRL_STATE state_q, state_d;
  logic rdy, is_bne, is_andi;
  logic mem_wr_raw, ir_wr_raw, pc_wr_raw, pc_wr_gated, pc_write;
  logic branch, bne_sel;

  assign rdy     = mem_ready | ~MEM_HS;
  assign is_bne  = EN_BNE  && (op == OP_BNE);
  assign is_andi = EN_ANDI && (op == OP_ANDI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW)     state_d = S_MEMADR;
        else if (op == OP_RTYPE)            state_d = S_EXEC;
        else if (op == OP_BEQ || is_bne)    state_d = S_BRANCH;
        else if (op == OP_ADDI || is_andi)  state_d = S_IMMEX;
        else if (op == OP_J)                state_d = S_JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (rdy) state_d = S_MEMWB;
      S_MEMWR:  if (rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      default:  state_d = S_FETCH;
    endcase
  end

  ctrl_out_dec u_dec (
    .state_i       (state_q),
    .is_bne_i      (is_bne),
    .is_andi_i     (is_andi),
    .mem_req_o     (mem_req),
    .mem_wr_o      (mem_wr_raw),
    .ir_wr_o       (ir_wr_raw),
    .pc_wr_o       (pc_wr_raw),
    .pc_wr_gated_o (pc_wr_gated),
    .i_or_d_o      (i_or_d),
    .mem_to_reg_o  (mem_to_reg),
    .reg_dst_o     (reg_dst),
    .reg_write_o   (reg_write),
    .alu_src_a_o   (alu_src_a),
    .alu_src_b_o   (alu_src_b),
    .imm_zext_o    (imm_zext),
    .pc_src_o      (pc_src),
    .alu_op_o      (alu_op),
    .branch_o      (branch),
    .bne_sel_o     (bne_sel)
  );

  // FETCH's PC increment waits on ready; JUMP's PC write does not.
  assign pc_write  = pc_wr_raw & (~pc_wr_gated | rdy);
  assign mem_write = mem_wr_raw & rdy;
  assign ir_write  = ir_wr_raw & rdy;
  assign pc_en     = pc_write | (branch & (zero ^ bne_sel));
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: default build plus a build with
// BNE/ANDI disabled and the memory handshake ignored.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic mem_req, mem_write, ir_write, pc_en, i_or_d, mem_to_reg, reg_dst;
  logic reg_write, alu_src_a, imm_zext, illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] state_o;

  logic mem_req_n, mem_write_n, ir_write_n, pc_en_n, i_or_d_n, mem_to_reg_n, reg_dst_n;
  logic reg_write_n, alu_src_a_n, imm_zext_n, illegal_op_n;
  logic [1:0] alu_src_b_n, pc_src_n, alu_op_n;
  logic [3:0] state_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_HS(1'b1), .EN_BNE(1'b1), .EN_ANDI(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_src(pc_src),
    .alu_op(alu_op), .illegal_op(illegal_op), .state_o(state_o)
  );

  multicycle_ctrl #(.MEM_HS(1'b0), .EN_BNE(1'b0), .EN_ANDI(1'b0)) u_nx (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_n), .mem_write(mem_write_n), .ir_write(ir_write_n), .pc_en(pc_en_n),
    .i_or_d(i_or_d_n), .mem_to_reg(mem_to_reg_n), .reg_dst(reg_dst_n), .reg_write(reg_write_n),
    .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .imm_zext(imm_zext_n), .pc_src(pc_src_n),
    .alu_op(alu_op_n), .illegal_op(illegal_op_n), .state_o(state_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset, release it, and leave both DUTs in FETCH.
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [17:0] ctl;
    #2;
    ctl = {mem_req, mem_write, ir_write, pc_en, reg_write, illegal_op, i_or_d, mem_to_reg,
           reg_dst, alu_src_a, alu_src_b, imm_zext, pc_src, alu_op};
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (ctl !== 18'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", ctl); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_idle_after_release: got %0d expected 0", state_o); end
    tick();
    #1;
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL reset_to_fetch: got %0d expected 1", state_o); end
  endtask

  task automatic test_lw();
    logic [3:0] st [6];
    logic       rw [6];
    st = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    rw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    apply_reset();
    op = 6'b100011;
    mem_ready = 1'b1;
    #1;
    checks++; if ({ir_write, pc_en, mem_req, alu_src_b} !== 5'b11101) begin errors++; $display("FAIL lw_fetch_ctl: got %b expected 11101", {ir_write, pc_en, mem_req, alu_src_b}); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) #1;
      checks++; if (state_o !== st[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state_o, st[i]); end
      checks++; if (reg_write !== rw[i]) begin errors++; $display("FAIL lw_reg_write[%0d]: got %b expected %b", i, reg_write, rw[i]); end
      if (state_o == 4'd5) begin
        checks++; if (mem_to_reg !== 1'b1) begin errors++; $display("FAIL lw_mem_to_reg: got %b expected 1", mem_to_reg); end
      end
      tick();
    end
  endtask

  task automatic test_sw_stall();
    apply_reset();
    op = 6'b101011;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (state_o !== 4'd6) begin errors++; $display("FAIL sw_stall_state[%0d]: got %0d expected 6", i, state_o); end
      checks++; if ({mem_req, i_or_d, mem_write} !== 3'b110) begin errors++; $display("FAIL sw_stall_ctl[%0d]: got %b expected 110", i, {mem_req, i_or_d, mem_write}); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if ({state_o, mem_req, i_or_d, mem_write} !== 7'b0110111) begin errors++; $display("FAIL sw_ready_ctl: got %b expected 0110111", {state_o, mem_req, i_or_d, mem_write}); end
    tick();
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL sw_to_fetch: got %0d expected 1", state_o); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [3];
    logic       zs  [3];
    logic       pe  [3];
    ops = '{6'b000100, 6'b000101, 6'b000101};
    zs  = '{1'b1, 1'b1, 1'b0};
    pe  = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      apply_reset();
      op = ops[i];
      zero = zs[i];
      tick();
      tick();
      #1;
      checks++; if (state_o !== 4'd9) begin errors++; $display("FAIL br_state[%0d]: got %0d expected 9", i, state_o); end
      checks++; if (pc_en !== pe[i]) begin errors++; $display("FAIL br_pc_en[%0d]: got %b expected %b", i, pc_en, pe[i]); end
      checks++; if ({pc_src, alu_op, alu_src_a} !== 5'b01011) begin errors++; $display("FAIL br_ctl[%0d]: got %b expected 01011", i, {pc_src, alu_op, alu_src_a}); end
      tick();
      checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL br_to_fetch[%0d]: got %0d expected 1", i, state_o); end
    end
    zero = 1'b0;
  endtask

  task automatic test_andi();
    apply_reset();
    op = 6'b001100;
    tick();
    #1;
    checks++; if ({illegal_op_n, state_n} !== 5'b10010) begin errors++; $display("FAIL andi_dis_decode: got %b expected 10010", {illegal_op_n, state_n}); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL andi_en_no_illegal: got %b expected 0", illegal_op); end
    tick();
    #1;
    checks++; if ({state_o, alu_op, imm_zext, alu_src_b} !== 9'b101011110) begin errors++; $display("FAIL andi_immex: got %b expected 101011110", {state_o, alu_op, imm_zext, alu_src_b}); end
    checks++; if ({state_n, reg_write_n} !== 5'b00010) begin errors++; $display("FAIL andi_dis_fetch: got %b expected 00010", {state_n, reg_write_n}); end
    tick();
    #1;
    checks++; if ({state_o, reg_write, reg_dst, mem_to_reg} !== 7'b1011100) begin errors++; $display("FAIL andi_immwb: got %b expected 1011100", {state_o, reg_write, reg_dst, mem_to_reg}); end
    tick();
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL andi_to_fetch: got %0d expected 1", state_o); end
  endtask

  task automatic test_illegal();
    int pulses;
    pulses = 0;
    apply_reset();
    op = 6'b111111;
    tick();
    #1;
    if (illegal_op === 1'b1) pulses++;
    checks++; if ({state_o, reg_write, mem_write, pc_en, ir_write} !== 8'b00100000) begin errors++; $display("FAIL ill_decode: got %b expected 00100000", {state_o, reg_write, mem_write, pc_en, ir_write}); end
    mem_ready = 1'b0;
    tick();
    #1;
    if (illegal_op === 1'b1) pulses++;
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL ill_to_fetch: got %0d expected 1", state_o); end
    tick();
    #1;
    if (illegal_op === 1'b1) pulses++;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ill_pulse_count: got %0d expected 1", pulses); end
    mem_ready = 1'b1;
  endtask

  task automatic test_jump_rtype();
    apply_reset();
    op = 6'b000010;
    tick();
    tick();
    #1;
    checks++; if ({state_o, pc_en, pc_src} !== 7'b1100110) begin errors++; $display("FAIL j_ctl: got %b expected 1100110", {state_o, pc_en, pc_src}); end
    tick();
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL j_to_fetch: got %0d expected 1", state_o); end
    apply_reset();
    op = 6'b000000;
    tick();
    tick();
    #1;
    checks++; if ({state_o, alu_op, alu_src_a, alu_src_b} !== 9'b011110100) begin errors++; $display("FAIL r_exec: got %b expected 011110100", {state_o, alu_op, alu_src_a, alu_src_b}); end
    tick();
    checks++; if ({state_o, reg_write, reg_dst, mem_to_reg} !== 7'b1000110) begin errors++; $display("FAIL r_aluwb: got %b expected 1000110", {state_o, reg_write, reg_dst, mem_to_reg}); end
  endtask

  task automatic test_no_handshake();
    apply_reset();
    op = 6'b000000;
    mem_ready = 1'b0;
    #1;
    checks++; if ({ir_write, pc_en} !== 2'b00) begin errors++; $display("FAIL nohs_dut_gated: got %b expected 00", {ir_write, pc_en}); end
    checks++; if ({ir_write_n, pc_en_n} !== 2'b11) begin errors++; $display("FAIL nohs_ignores_ready: got %b expected 11", {ir_write_n, pc_en_n}); end
    tick();
    #1;
    checks++; if ({state_o, state_n} !== 8'h12) begin errors++; $display("FAIL nohs_states: got %h expected 12", {state_o, state_n}); end
    mem_ready = 1'b1;
  endtask

  task automatic test_reset_midop();
    apply_reset();
    op = 6'b100011;
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
    checks++; if ({state_o, mem_req, i_or_d} !== 6'b010011) begin errors++; $display("FAIL mid_stalled_memrd: got %b expected 010011", {state_o, mem_req, i_or_d}); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if ({state_o, mem_req, i_or_d} !== 6'b000000) begin errors++; $display("FAIL mid_async_reset: got %b expected 000000", {state_o, mem_req, i_or_d}); end
    @(negedge clk);
    mem_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL mid_idle: got %0d expected 0", state_o); end
    tick();
    checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL mid_fetch: got %0d expected 1", state_o); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch();
    test_andi();
    test_illegal();
    test_jump_rtype();
    test_no_handshake();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main controller for the multicycle MIPS core. It replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several clocks.
- Sits in cpu/controller beside the ALU decoder. It drives the shared-memory, IR, PC and register-file enables of the multicycle datapath.
- New relative to the single-cycle decoder:
  - optional memory ready/valid stall;
  - optional BNE and ANDI support;
  - illegal-opcode flag;
  - state export for debug.

Parameters:
- MEM_HS, 1, 1: FETCH/MEMRD/MEMWR wait for mem_ready. 0: mem_ready is ignored and treated as 1.
- EN_BNE, 1, decode BNE (opcode 6'b000101). When 0, BNE is illegal.
- EN_ANDI, 1, decode ANDI (opcode 6'b001100). When 0, ANDI is illegal.

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- op  in  6  IR[31:26], type OPECODE
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe
- ir_write  out  1  IR load enable
- pc_en  out  1  PC register enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_to_reg  out  1  writeback select: 1 = Data register
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- imm_zext  out  1  1 = zero-extend the immediate (ANDI)
- pc_src  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = and
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state_o  out  4  current state, for debug

Behaviour:
- Reset:
  - State goes to S_IDLE asynchronously.
  - All enables (mem_req, mem_write, ir_write, pc_en, reg_write) and illegal_op are 0. All selects are 0.
  - S_IDLE moves to S_FETCH on the first clk edge after reset_n rises. S_IDLE is never re-entered except through reset.
- Outputs are a combinational decode of state, except:
  - pc_en = pc_write | (branch & (zero ^ bne_sel));
  - mem-gated strobes are ANDed with the effective ready (mem_ready | ~MEM_HS).
  - Unlisted outputs are 0 in every state.
- State encoding, 4 bits: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, IMMEX=10, IMMWB=11, JUMP=12.
- FETCH:
  - mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write = rdy.
  - Stay in FETCH until rdy, then go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - LW/SW (100011/101011) -> MEMADR
    - RTYPE (000000) -> EXEC
    - BEQ (000100), or BNE when EN_BNE -> BRANCH
    - ADDI (001000), or ANDI when EN_ANDI -> IMMEX
    - J (000010) -> JUMP
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH, no architectural write.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, i_or_d=1. Wait for rdy, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_req=1, i_or_d=1, mem_write=rdy. Wait for rdy, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
  - bne_sel=1 when the latched opcode is BNE. The IR is stable here, so op may be used directly.
  - Then FETCH.
- IMMEX:
  - alu_src_a=1, alu_src_b=10.
  - ADDI: alu_op=00, imm_zext=0. ANDI: alu_op=11, imm_zext=1.
  - Then IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- JUMP: pc_src=10, pc_write=1. Then FETCH.
- Stalls: while waiting for rdy, all selects are held constant and strobes stay 0. A request may stall indefinitely; there is no timeout.
- Reset mid-operation (any state, including a stalled MEMWR): enables drop to 0 immediately and asynchronously. No partial write is issued after reset_n falls.
- CPI:
  - With mem_ready tied to 1: LW 5, SW 4, RTYPE 4, ADDI/ANDI 4, BEQ/BNE 3, J 3.
  - Each stall cycle adds 1.

Decomposition:
- lib_cpu package: OPECODE enum extended with BNE and ANDI; ALUOP typedef (2-bit); CTRL_STATE enum (4-bit, values above); ALU_SRC_B and PC_SRC constants.
- Sub-module ctrl_out_dec: combinational map from state (plus latched opcode class) to the control word, one case per state.
- multicycle_ctrl keeps the state register, the next-state logic, ready gating and the pc_en equation.

Test Plan:
- Reset then LW (op=100011), mem_ready=1 -> states 0,1,2,3,4,5,1. reg_write=1 only in MEMWB; mem_to_reg=1.
- SW with mem_ready low for 3 cycles in MEMWR -> mem_write=0 for 3 cycles, 1 in the cycle ready rises. Next state is FETCH; i_or_d=1 throughout.
- BEQ with zero=1 -> pc_en=1, pc_src=01 in BRANCH. BNE with zero=1 -> pc_en=0. BNE with zero=0 -> pc_en=1.
- ANDI (op=001100), EN_ANDI=1 -> IMMEX gives alu_op=11, imm_zext=1; IMMWB gives reg_write=1. With EN_ANDI=0 -> illegal_op pulse in DECODE, next state FETCH, no reg_write.
- Opcode 6'b111111 -> illegal_op=1 for exactly one cycle, no writes, back in FETCH.
- Assert reset_n=0 during stalled MEMRD -> mem_req drops the same cycle, state_o=0. After release: IDLE, then FETCH.
